// File: rtl/mandelbrot_frame_ctrl.sv
// -----------------------------------------------------------------------------
// mandelbrot_frame_ctrl
//
// Purpose:
//   Frame-level sequencer for the mandelbrot iteration engine. It requests one
//   pixel at a time from the engine and captures each 4-bit result into a
//   small first-word-fall-through FIFO. The FIFO also stores a flag that marks
//   the last pixel of each frame. The block owns the view registers
//   (cr_offset, ci_offset and scaling). Pan/zoom commands are accepted only
//   between frames, so a frame is never rendered with a mixed view.
//
// Optional build macro:
//   MANDEL_CTRL_STATS_EN - adds the frame_cycles[23:0] output, which holds the
//                          cycle count of the most recent frame (saturating).
//
// Parameters:
//   BITWIDTH   - width of the view offsets and pan deltas (must match engine)
//   FIFO_DEPTH - pixel FIFO entries, power of two, >= 2
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   start, continuous           frame start pulse and auto-restart level
//   busy, frame_done            status: not idle and end-of-frame pulse
//   eng_run                     one-cycle run request to the engine
//   eng_running, eng_finished   engine status inputs
//   eng_ctr_out                 engine pixel result
//   cr_offset, ci_offset        view offsets driven to the engine
//   scaling                     view step driven to the engine
//   cfg_valid / cfg_ready       view command handshake
//   cfg_dx, cfg_dy              signed pan deltas (wrap modulo 2^BITWIDTH)
//   cfg_zoom_in, cfg_zoom_out   saturating scaling decrement/increment
//   pix_valid / pix_ready       pixel stream handshake (FIFO head)
//   pix_data, pix_last          head pixel and its end-of-frame flag
//   frame_cycles                (MANDEL_CTRL_STATS_EN only) frame cycle count
// -----------------------------------------------------------------------------
module mandelbrot_frame_ctrl #(
  parameter int BITWIDTH   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  output logic                busy,
  output logic                frame_done,
  output logic                eng_run,
  input  logic                eng_running,
  input  logic                eng_finished,
  input  logic [3:0]          eng_ctr_out,
  output logic [BITWIDTH-1:0] cr_offset,
  output logic [BITWIDTH-1:0] ci_offset,
  output logic [1:0]          scaling,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [BITWIDTH-1:0] cfg_dx,
  input  logic [BITWIDTH-1:0] cfg_dy,
  input  logic                cfg_zoom_in,
  input  logic                cfg_zoom_out,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [3:0]          pix_data,
  output logic                pix_last
`ifdef MANDEL_CTRL_STATS_EN
  ,
  output logic [23:0]         frame_cycles
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_PUSH,
    S_FRAME_END
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_eng_run;
  logic                r_cfg_ready;
  logic                r_cap_last;
  logic [3:0]          r_cap_data;

  logic [BITWIDTH-1:0] r_cr_offset;
  logic [BITWIDTH-1:0] r_ci_offset;
  logic [1:0]          r_scaling;

  logic [4:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_fifo_space;
  logic                w_fifo_nonempty;
  logic                w_push;
  logic                w_pop;
  logic                w_cfg_fire;
  logic [4:0]          w_head;

  assign w_fifo_nonempty = (r_count != '0);
  assign w_fifo_space    = (r_count < DEPTH_C);
  assign w_pop           = w_fifo_nonempty && pix_ready;
  // Only one pixel is ever in flight, so PUSH always finds space. The pop term
  // keeps a simultaneous push/pop at full well defined anyway.
  assign w_push          = (r_state == S_PUSH) && (w_fifo_space || w_pop);
  assign w_cfg_fire      = cfg_valid && r_cfg_ready;

  // ---------------------------------------------------------------------------
  // Frame sequencer. All outputs are registered and updated on the transition
  // into the state that owns them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_eng_run    <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_cap_last   <= 1'b0;
      r_cap_data   <= 4'd0;
    end else begin
      r_eng_run    <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // eng_finished=1 means the engine sits at a frame boundary; a start
          // request at any other time would desynchronise the pixel count.
          if (start && eng_finished) begin
            r_state     <= S_ISSUE;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (w_fifo_space) begin
            r_eng_run <= 1'b1;
            r_state   <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (eng_running) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // The engine's result is valid in the cycle running drops. It is
          // captured here, so the FIFO write does not depend on the engine
          // holding its outputs for another cycle.
          if (!eng_running) begin
            r_cap_last <= eng_finished;
            r_cap_data <= eng_ctr_out;
            r_state    <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (r_cap_last) begin
            r_state      <= S_FRAME_END;
            r_frame_done <= 1'b1;
            r_cfg_ready  <= 1'b1;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_FRAME_END: begin
          if (continuous) begin
            r_state     <= S_ISSUE;
            r_cfg_ready <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // View registers. They only move while cfg_ready is high (idle or frame
  // boundary), so every pixel in a frame uses the same view.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cr_offset <= '0;
      r_ci_offset <= '0;
      r_scaling   <= 2'd0;
    end else if (w_cfg_fire) begin
      r_cr_offset <= r_cr_offset + cfg_dx;
      r_ci_offset <= r_ci_offset + cfg_dy;
      if (cfg_zoom_in && !cfg_zoom_out) begin
        if (r_scaling != 2'd0) begin
          r_scaling <= r_scaling - 2'd1;
        end
      end else if (cfg_zoom_out && !cfg_zoom_in) begin
        if (r_scaling != 2'd3) begin
          r_scaling <= r_scaling + 2'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel FIFO: first-word-fall-through. Storage has no reset; the gated head
  // output keeps pix_data/pix_last at 0 whenever the FIFO is empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_cap_last, r_cap_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = w_fifo_nonempty ? r_mem[r_rd_ptr] : 5'd0;

  // ---------------------------------------------------------------------------
  // Optional frame cycle counter
  // ---------------------------------------------------------------------------
`ifdef MANDEL_CTRL_STATS_EN
  logic [23:0] r_frame_cycles;
  logic        r_first_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cycles <= 24'd0;
      r_first_run    <= 1'b0;
    end else begin
      // Every frame begins with an ISSUE entered from IDLE or FRAME_END, so
      // the next run request leaving ISSUE is the first one of a frame.
      if (r_state == S_IDLE || r_state == S_FRAME_END) begin
        r_first_run <= 1'b1;
      end
      if (r_state == S_ISSUE && w_fifo_space && r_first_run) begin
        r_frame_cycles <= 24'd0;
        r_first_run    <= 1'b0;
      end else if (r_busy && r_state != S_FRAME_END &&
                   r_frame_cycles != 24'hFFFFFF) begin
        r_frame_cycles <= r_frame_cycles + 24'd1;
      end
    end
  end

  assign frame_cycles = r_frame_cycles;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign eng_run    = r_eng_run;
  assign cfg_ready  = r_cfg_ready;
  assign cr_offset  = r_cr_offset;
  assign ci_offset  = r_ci_offset;
  assign scaling    = r_scaling;
  assign pix_valid  = w_fifo_nonempty;
  assign pix_data   = w_head[3:0];
  assign pix_last   = w_head[4];

endmodule

// File: tb/tb_mandelbrot_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mandelbrot_frame_ctrl
//
// Self-checking bench for mandelbrot_frame_ctrl. A behavioural engine model
// renders a 4x2 (8 pixel) frame; each finished pixel is pushed to a scoreboard
// queue, and the pixel-stream monitor pops and compares on every accepted
// pixel. Directed steps in one initial block cover reset, view commands,
// backpressure, continuous mode and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_mandelbrot_frame_ctrl;

  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          continuous;
  logic          busy;
  logic          frame_done;
  logic          eng_run;
  logic          eng_running;
  logic          eng_finished;
  logic [3:0]    eng_ctr_out;
  logic [BW-1:0] cr_offset;
  logic [BW-1:0] ci_offset;
  logic [1:0]    scaling;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [BW-1:0] cfg_dx;
  logic [BW-1:0] cfg_dy;
  logic          cfg_zoom_in;
  logic          cfg_zoom_out;
  logic          pix_valid;
  logic          pix_ready;
  logic [3:0]    pix_data;
  logic          pix_last;
`ifdef MANDEL_CTRL_STATS_EN
  logic [23:0]   frame_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int pix_cnt = 0;
  int last_cnt = 0;
  int run_cnt = 0;
  int fd_cnt = 0;

  logic [4:0] exp_q [$];
  logic [4:0] mon_exp;

  always #5 clk = ~clk;

  mandelbrot_frame_ctrl #(.BITWIDTH(BW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .busy         (busy),
    .frame_done   (frame_done),
    .eng_run      (eng_run),
    .eng_running  (eng_running),
    .eng_finished (eng_finished),
    .eng_ctr_out  (eng_ctr_out),
    .cr_offset    (cr_offset),
    .ci_offset    (ci_offset),
    .scaling      (scaling),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_dx       (cfg_dx),
    .cfg_dy       (cfg_dy),
    .cfg_zoom_in  (cfg_zoom_in),
    .cfg_zoom_out (cfg_zoom_out),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_last     (pix_last)
`ifdef MANDEL_CTRL_STATS_EN
    ,
    .frame_cycles (frame_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] pixval(input int idx, input int fr);
    return 4'((idx * 3 + fr * 5 + 2) % 16);
  endfunction

  // ---------------------------------------------------------------------------
  // Engine model: 8 pixels per frame, 2..4 iterations per pixel. A run while
  // finished=1 restarts at pixel 0 of a new frame.
  // ---------------------------------------------------------------------------
  int e_cur = 0;
  int e_iter = 0;
  int e_frame = 0;

  always @(posedge clk) begin
    int n;
    if (reset) begin
      eng_running  <= 1'b0;
      eng_finished <= 1'b1;
      eng_ctr_out  <= 4'd0;
      e_cur        <= 0;
      e_iter       <= 0;
    end else if (!eng_running && eng_run) begin
      n = eng_finished ? 0 : e_cur + 1;
      if (eng_finished) e_frame <= e_frame + 1;
      e_cur       <= n;
      e_iter      <= 2 + (n % 3);
      eng_running <= 1'b1;
    end else if (eng_running) begin
      if (e_iter == 1) begin
        eng_running  <= 1'b0;
        eng_ctr_out  <= pixval(e_cur, e_frame);
        eng_finished <= (e_cur == 7);
        exp_q.push_back({(e_cur == 7), pixval(e_cur, e_frame)});
        $display("engine: frame %0d pixel %0d value %0h last %0d",
                 e_frame, e_cur, pixval(e_cur, e_frame), (e_cur == 7));
      end else begin
        e_iter <= e_iter - 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel-stream monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_queue_size", exp_q.size(), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("pixel out: data %0h last %0d (expected %0h/%0d)",
                 pix_data, pix_last, mon_exp[3:0], mon_exp[4]);
        chk("pix_data", {28'd0, pix_data}, {28'd0, mon_exp[3:0]});
        chk("pix_last", {31'd0, pix_last}, {31'd0, mon_exp[4]});
      end
      pix_cnt++;
      if (pix_last) last_cnt++;
    end
    if (!reset && eng_run) run_cnt++;
    if (!reset && frame_done) fd_cnt++;
  end

  // Bounded wait for the FRAME_END cycle; returns at that cycle's negedge.
  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 3000);
    chk(tag, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_running(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!eng_running && n < 200);
    chk(tag, {31'd0, eng_running}, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r0, f0, l0, n;

    reset        = 1'b1;
    start        = 1'b0;
    continuous   = 1'b0;
    cfg_valid    = 1'b0;
    cfg_dx       = '0;
    cfg_dy       = '0;
    cfg_zoom_in  = 1'b0;
    cfg_zoom_out = 1'b0;
    pix_ready    = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // ---- reset state
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_eng_run", {31'd0, eng_run}, 32'd0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_pix_data", {28'd0, pix_data}, 32'd0);
    chk("rst_pix_last", {31'd0, pix_last}, 32'd0);
    chk("rst_cr", {22'd0, cr_offset}, 32'd0);
    chk("rst_ci", {22'd0, ci_offset}, 32'd0);
    chk("rst_scaling", {30'd0, scaling}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    // ---- view command in IDLE: dx=-3, dy=5, zoom_out
    step();
    cfg_valid = 1'b1; cfg_dx = 10'h3FD; cfg_dy = 10'd5; cfg_zoom_out = 1'b1;
    step();
    cfg_valid = 1'b0;
    @(negedge clk);
    $display("cfg: cr %0h ci %0h scaling %0d", cr_offset, ci_offset, scaling);
    chk("cfg_cr", {22'd0, cr_offset}, 32'h3FD);
    chk("cfg_ci", {22'd0, ci_offset}, 32'd5);
    chk("cfg_scaling1", {30'd0, scaling}, 32'd1);

    step();
    cfg_valid = 1'b1; cfg_dx = '0; cfg_dy = '0; cfg_zoom_out = 1'b1;
    repeat (3) step();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("cfg_scaling_sat3", {30'd0, scaling}, 32'd3);

    step();
    cfg_valid = 1'b1; cfg_zoom_in = 1'b1; cfg_zoom_out = 1'b1;
    step();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("cfg_zoom_both", {30'd0, scaling}, 32'd3);

    step();
    cfg_valid = 1'b1; cfg_zoom_in = 1'b1; cfg_zoom_out = 1'b0;
    step();
    cfg_valid = 1'b0; cfg_zoom_in = 1'b0;
    @(negedge clk);
    chk("cfg_zoom_in", {30'd0, scaling}, 32'd2);
    chk("cfg_cr_kept", {22'd0, cr_offset}, 32'h3FD);

    // ---- single frame, pix_ready=1
    p0 = pix_cnt; f0 = fd_cnt; l0 = last_cnt;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_frame("f1_frame_done");
    @(negedge clk);
    $display("frame1: pixels %0d lasts %0d done pulses %0d", pix_cnt - p0, last_cnt - l0, fd_cnt - f0);
    chk("f1_busy_idle", {31'd0, busy}, 32'd0);
    chk("f1_pixels", pix_cnt - p0, 32'd8);
    chk("f1_lasts", last_cnt - l0, 32'd1);
    chk("f1_done_pulses", fd_cnt - f0, 32'd1);
    chk("f1_sb_empty", exp_q.size(), 32'd0);

    // ---- backpressure: FIFO fills with 4 pixels, engine held off
    p0 = pix_cnt; r0 = run_cnt;
    step();
    pix_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (150) @(negedge clk);
    chk("bp_runs", run_cnt - r0, 32'd4);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    chk("bp_pix_valid", {31'd0, pix_valid}, 32'd1);
    chk("bp_sb_depth", exp_q.size(), 32'd4);
    if (exp_q.size() != 0) begin
      chk("bp_head_data", {28'd0, pix_data}, {28'd0, exp_q[0][3:0]});
    end
    chk("bp_head_last", {31'd0, pix_last}, 32'd0);
    repeat (30) @(negedge clk);
    chk("bp_runs_held", run_cnt - r0, 32'd4);
    step();
    pix_ready = 1'b1;
    wait_frame("bp_frame_done");
    @(negedge clk);
    $display("backpressure frame: pixels %0d runs %0d", pix_cnt - p0, run_cnt - r0);
    chk("bp_pixels", pix_cnt - p0, 32'd8);
    chk("bp_runs_total", run_cnt - r0, 32'd8);
    chk("bp_busy_idle", {31'd0, busy}, 32'd0);

    // ---- cfg during WAIT_DONE is held off until FRAME_END
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_running("wd_running");
    step();
    cfg_valid = 1'b1; cfg_dx = 10'd1; cfg_dy = 10'd0;
    @(negedge clk);
    chk("wd_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    chk("wd_cr_unchanged", {22'd0, cr_offset}, 32'h3FD);
    wait_frame("wd_frame_done");
    chk("fe_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("fe_cr_before", {22'd0, cr_offset}, 32'h3FD);
    step();
    cfg_valid = 1'b0; cfg_dx = '0;
    @(negedge clk);
    $display("cfg at frame end: cr %0h", cr_offset);
    chk("fe_cr_after", {22'd0, cr_offset}, 32'h3FE);
    chk("fe_busy_idle", {31'd0, busy}, 32'd0);

    // ---- continuous: back-to-back frames, drop mid frame 2
    p0 = pix_cnt; f0 = fd_cnt;
    step();
    continuous = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_frame("cont_f1_done");
    @(negedge clk);
    chk("cont_issue_busy", {31'd0, busy}, 32'd1);
    chk("cont_issue_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    r0 = run_cnt;
    n = 0;
    while (run_cnt - r0 < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cont_f2_progress", {31'd0, (run_cnt - r0 >= 3)}, 32'd1);
    step();
    continuous = 1'b0;
    wait_frame("cont_f2_done");
    @(negedge clk);
    $display("continuous: pixels %0d done pulses %0d", pix_cnt - p0, fd_cnt - f0);
    chk("cont_idle", {31'd0, busy}, 32'd0);
    chk("cont_pixels", pix_cnt - p0, 32'd16);
    chk("cont_done_pulses", fd_cnt - f0, 32'd2);

    // ---- reset asserted in WAIT_DONE
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_running("rst_mid_running");
    step();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rmid_eng_run", {31'd0, eng_run}, 32'd0);
    chk("rmid_cr", {22'd0, cr_offset}, 32'd0);
    chk("rmid_ci", {22'd0, ci_offset}, 32'd0);
    chk("rmid_scaling", {30'd0, scaling}, 32'd0);
    step();
    reset = 1'b0;
    p0 = pix_cnt; l0 = last_cnt;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_frame("rpost_frame_done");
    @(negedge clk);
    $display("post-reset frame: pixels %0d lasts %0d", pix_cnt - p0, last_cnt - l0);
    chk("rpost_pixels", pix_cnt - p0, 32'd8);
    chk("rpost_lasts", last_cnt - l0, 32'd1);
    chk("rpost_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mandelbrot_frame_ctrl.md
Name: mandelbrot_frame_ctrl

Overview:
Frame-level sequencer for the mandelbrot iteration engine. Issues one run pulse per pixel and captures each finished 4-bit ctr_out into a small output FIFO with an end-of-frame flag. Owns the view registers (cr_offset, ci_offset, scaling) and applies pan/zoom commands only between frames. Sits between the engine and the display/streaming sink.

Parameters:
BITWIDTH, 10, width of the cr_offset/ci_offset/pan fields; matches the engine.
FIFO_DEPTH, 4, pixel FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse: render one frame (IDLE only)
continuous  in  1  level: auto-restart after each frame while high
busy  out  1  high when state != IDLE
frame_done  out  1  one-cycle pulse in FRAME_END
eng_run  out  1  engine run request
eng_running  in  1  engine running status
eng_finished  in  1  engine finished flag
eng_ctr_out  in  4  engine pixel result
cr_offset  out  BITWIDTH  view real offset to engine
ci_offset  out  BITWIDTH  view imag offset to engine
scaling  out  2  view step to engine
cfg_valid  in  1  view command valid
cfg_ready  out  1  high in IDLE and FRAME_END only
cfg_dx  in  BITWIDTH  signed real pan delta
cfg_dy  in  BITWIDTH  signed imag pan delta
cfg_zoom_in  in  1  scaling-1, saturating at 0
cfg_zoom_out  in  1  scaling+1, saturating at 3
pix_valid  out  1  FIFO non-empty
pix_ready  in  1  sink accepts
pix_data  out  4  FIFO head pixel
pix_last  out  1  head is last pixel of frame

Behaviour:
- Reset: state IDLE; FIFO empty; eng_run=0, busy=0, frame_done=0, pix_valid=0, pix_data=0, pix_last=0; cr_offset=0, ci_offset=0, scaling=0. The engine shares this reset.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, PUSH, FRAME_END.
- IDLE: when start=1 and eng_finished=1, go to ISSUE. If start=1 while eng_finished=0, ignore it.
- ISSUE: when FIFO count < FIFO_DEPTH, drive eng_run=1 for exactly one cycle and go to WAIT_START. Otherwise hold with eng_run=0 (backpressure).
- WAIT_START: wait for eng_running=1, then go to WAIT_DONE.
- WAIT_DONE: wait for eng_running=0. eng_ctr_out and eng_finished are valid in that cycle; go to PUSH.
- PUSH: write {eng_finished, eng_ctr_out} into the FIFO. Space is guaranteed because only one pixel is ever in flight. If eng_finished=1, go to FRAME_END, else go to ISSUE.
- FRAME_END: one cycle with frame_done=1. Go to ISSUE if continuous=1, else IDLE.
- Latency: eng_run to FIFO write is engine iterations + 3 cycles.
- Config handshake:
  - Accepted on clk edge when cfg_valid && cfg_ready.
  - cr_offset += cfg_dx and ci_offset += cfg_dy, wrapping modulo 2^BITWIDTH.
  - zoom_in and zoom_out both set: scaling unchanged.
  - Offsets and scaling never change outside IDLE and FRAME_END. An accepted update is therefore visible at the engine's next frame-start run.
  - start and cfg accepted in the same cycle: the new view applies to that frame.
- FIFO:
  - Standard first-word-fall-through; pop on pix_valid && pix_ready.
  - Push and pop in the same cycle at full: count unchanged.
  - pix_data/pix_last reflect the head entry; both are 0 when empty.
- continuous dropping mid-frame: the current frame completes, then return to IDLE.
- start outside IDLE: ignored.
- Reset mid-frame: immediate return to IDLE, FIFO flushed, view registers cleared.

Optional Feature:
MANDEL_CTRL_STATS_EN
- Enabled: adds output frame_cycles [23:0].
  - Counter clears on the cycle the first eng_run of a frame is issued.
  - Increments every cycle while busy, saturating at 24'hFFFFFF.
  - Value is held from FRAME_END until the next frame starts; reset value 0.
- Disabled: port and logic absent; the rest of the behaviour is identical.

Test Plan:
- Engine 4x2 frame, pix_ready=1, start pulse -> 8 pixels emitted, only the 8th has pix_last=1, one frame_done pulse, back to IDLE with busy=0.
- pix_ready=0 with FIFO_DEPTH=4 -> exactly 4 pixels captured and eng_run held 0 in ISSUE. Raise pix_ready -> remaining 4 pixels flow in order.
- In IDLE, cfg_dx=-3, cfg_dy=5, cfg_zoom_out=1 from reset -> cr_offset=10'h3FD, ci_offset=5, scaling=1. zoom_out x3 more -> scaling stays 3.
- cfg_valid during WAIT_DONE -> cfg_ready=0, offsets unchanged. The same command is accepted in the FRAME_END cycle.
- continuous=1 -> back-to-back frames with FRAME_END directly followed by ISSUE. Drop continuous mid-frame 2 -> frame 2 completes, then IDLE.
- Reset asserted in WAIT_DONE -> next cycle IDLE, pix_valid=0, eng_run=0, offsets 0. A subsequent start renders a full 8-pixel frame.
